msrv32_fetch_ctrl: RTL and testbench
====================================

Name: msrv32_fetch_ctrl

Overview:
- Sequences instruction fetch for the MS-RV32 core.
- Drives the instruction-memory request/grant/response handshake, buffers fetched words in a 2-entry skid FIFO, and presents one instruction per cycle to the instruction mux.
- On redirects (branch, jump, trap) it discards in-flight fetches and pulses flush_out, which drives the instruction mux flush_in.

Parameters:
- BOOT_ADDR, 32'h0000_0000, PC fetched first after reset.
- TIMEOUT_CYCLES, 16, max cycles from grant to response before fetch_err_out asserts.
- NOP_INSTR, 32'h0000_0013, value driven on instr_out when nothing is valid (addi x0,x0,0).

Ports:
- ms_riscv32_mp_clk_in  in  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  in  1  asynchronous, active-low reset.
- imem_req_out  out  1  fetch request; held until granted.
- imem_addr_out  out  32  word-aligned fetch address; stable while imem_req_out=1.
- imem_gnt_in  in  1  request accepted this cycle.
- imem_rvalid_in  in  1  response data valid; at most one per grant; never in the grant cycle.
- imem_rdata_in  in  32  fetched instruction.
- redirect_in  in  1  one-cycle pulse requesting a PC redirect.
- redirect_pc_in  in  32  redirect target; bits [1:0] are ignored (forced to 0).
- stall_in  in  1  decode cannot accept the instruction this cycle.
- instr_valid_out  out  1  instr_out/pc_out hold a valid instruction.
- instr_out  out  32  head-of-FIFO instruction, or NOP_INSTR when not valid.
- pc_out  out  32  PC of instr_out.
- flush_out  out  1  one-cycle pulse on the cycle after redirect_in.
- fetch_err_out  out  1  sticky fetch timeout; cleared by redirect_in.

Behaviour:
- Reset (async assert, sync release) drives these values:
  - imem_req_out=0, imem_addr_out=BOOT_ADDR.
  - FIFO empty: instr_valid_out=0, instr_out=NOP_INSTR, pc_out=BOOT_ADDR.
  - flush_out=0, fetch_err_out=0, state=S_BOOT.
- Reset asserted mid-fetch abandons the request. After reset, any stale imem_rvalid_in is a memory-side protocol violation and is not handled.
- States:
  - S_BOOT: lasts 1 cycle, then goes to S_REQ.
  - S_REQ: imem_req_out=1 only when occupancy + outstanding < 2 (outstanding is 0 here); otherwise req=0 and the controller waits. On imem_gnt_in, go to S_WAIT, outstanding=1, fetch_pc advances by 4 (wraps modulo 2^32).
  - S_WAIT: req=0; the timeout counter increments each cycle. On imem_rvalid_in, push {fetch_pc_of_req, rdata} and go to S_REQ. If the counter reaches TIMEOUT_CYCLES, set fetch_err_out and stay in S_WAIT.
  - S_DRAIN: waits for the discarded response. On imem_rvalid_in, drop the data and go to S_REQ. The timeout applies here too.
- Skid FIFO (2 entries):
  - Pop when instr_valid_out & !stall_in.
  - A push and a pop in the same cycle is legal; occupancy is unchanged.
  - A push into a full FIFO cannot occur because of the issue rule.
  - Response-to-output latency is 1 cycle: data is registered into the FIFO and becomes visible the next cycle.
- Redirect (redirect_in=1), with priority over every other event in the same cycle:
  - The FIFO is cleared: instr_valid_out=0 next cycle, and any pop that cycle is ignored.
  - fetch_pc <= {redirect_pc_in[31:2],2'b00}; fetch_err_out and the timeout counter clear.
  - flush_out=1 for exactly one cycle (the next one).
  - If a response is outstanding (S_WAIT, or S_REQ with imem_gnt_in=1 this cycle), go to S_DRAIN; otherwise go to S_REQ.
  - imem_rvalid_in in the redirect cycle itself: the data is discarded, outstanding clears, and the state goes to S_REQ.
  - A second redirect during S_DRAIN updates fetch_pc and pulses flush again; the state stays in S_DRAIN.
- Throughput: best case is 1 instruction per 2 cycles with zero-wait memory (single outstanding request). This is the accepted limitation.

Decomposition:
- Shared package msrv32_pkg holds:
  - State enum: S_BOOT, S_REQ, S_WAIT, S_DRAIN.
  - Constant NOP_INSTR.
  - Constant PC_INCR=4.
- One sub-module: msrv32_fetch_skid_fifo (2-entry, 64-bit {pc,instr}; push, pop, clear, count, head).

Test Plan:
1. Reset release, memory grants the same cycle and returns 32'h00000093 two cycles later -> first imem_addr_out=BOOT_ADDR, then instr_valid_out=1, instr_out=32'h00000093, pc_out=0, next imem_addr_out=4.
2. stall_in held high for 10 cycles with zero-wait memory -> exactly 2 instructions buffered (PC 0, 4); req stays 0; on stall release, PC 0 and PC 4 pop on consecutive cycles.
3. redirect_in with redirect_pc_in=32'h00000103 while in S_WAIT -> flush_out=1 next cycle, instr_valid_out=0, the next rvalid data is discarded, and the next request address is 32'h00000100.
4. Redirect in the same cycle as imem_rvalid_in -> data discarded, no S_DRAIN, next request goes to the redirect target.
5. Memory withholds rvalid for 20 cycles -> fetch_err_out=1 at grant+16; a subsequent redirect clears it and drains the late response.
6. Reset asserted during S_WAIT -> all outputs return to their reset values immediately (asynchronously), and fetch restarts at BOOT_ADDR.

Source files
------------

// File: rtl/msrv32_pkg.sv
// Shared types and constants for the MS-RV32 instruction fetch path.
package msrv32_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_REQ,
        S_WAIT,
        S_DRAIN
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

endpackage

// File: rtl/msrv32_fetch_skid_fifo.sv
// Two-entry {pc, instr} buffer between the instruction memory and decode.
module msrv32_fetch_skid_fifo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    input  logic        clear,
    output logic [1:0]  count,
    output logic [63:0] head
);

    logic [63:0] mem [2];
    logic        rd_ptr;
    logic        wr_ptr;

    // Storage carries no reset; the head is only meaningful while count is non-zero.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/msrv32_fetch_ctrl.sv
// Instruction fetch sequencer: single-outstanding memory handshake, skid buffering, redirect flush.
module msrv32_fetch_ctrl #(
    parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    input  logic        redirect_in,
    input  logic [31:0] redirect_pc_in,
    input  logic        stall_in,
    output logic        instr_valid_out,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        flush_out,
    output logic        fetch_err_out
);

    import msrv32_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    fetch_state_t  state;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic [TW-1:0] timer;
    logic          flush_q;
    logic          err_q;
    logic [1:0]    count;
    logic [63:0]   head;
    logic          valid;
    logic          granted;
    logic          push;
    logic          pop;

    assign valid         = (count != 2'd0);
    assign imem_req_out  = (state == S_REQ) && (count < 2'd2);
    assign imem_addr_out = fetch_pc;
    assign granted       = imem_req_out && imem_gnt_in;

    // Redirect wins over both ends of the buffer in the same cycle.
    assign push = (state == S_WAIT) && imem_rvalid_in && !redirect_in;
    assign pop  = valid && !stall_in && !redirect_in;

    msrv32_fetch_skid_fifo u_skid_fifo (
        .clk       (ms_riscv32_mp_clk_in),
        .rst_n     (ms_riscv32_mp_rst_in),
        .push      (push),
        .push_data ({req_pc, imem_rdata_in}),
        .pop       (pop),
        .clear     (redirect_in),
        .count     (count),
        .head      (head)
    );

    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            state    <= S_BOOT;
            fetch_pc <= BOOT_ADDR;
            req_pc   <= BOOT_ADDR;
            timer    <= '0;
            flush_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (redirect_in) begin
            fetch_pc <= {redirect_pc_in[31:2], 2'b00};
            timer    <= '0;
            err_q    <= 1'b0;
            flush_q  <= 1'b1;
            // A response still owed by memory must be swallowed before re-issuing.
            if ((state == S_WAIT || state == S_DRAIN) && imem_rvalid_in) begin
                state <= S_REQ;
            end else if (state == S_WAIT || state == S_DRAIN || granted) begin
                state <= S_DRAIN;
            end else begin
                state <= S_REQ;
            end
        end else begin
            flush_q <= 1'b0;
            case (state)
                S_BOOT: state <= S_REQ;
                S_REQ: begin
                    if (granted) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + PC_INCR;
                        timer    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT, S_DRAIN: begin
                    if (imem_rvalid_in) begin
                        state <= S_REQ;
                    end else if (timer != TW'(TIMEOUT_CYCLES)) begin
                        timer <= timer + TW'(1);
                        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

    assign instr_valid_out = valid;
    assign instr_out       = valid ? head[31:0] : NOP_INSTR;
    assign pc_out          = valid ? head[63:32] : fetch_pc;
    assign flush_out       = flush_q;
    assign fetch_err_out   = err_q;

endmodule

// File: tb/tb_msrv32_fetch_ctrl.sv
// Randomized bench for msrv32_fetch_ctrl against a queue-based fetch model.
module tb_msrv32_fetch_ctrl;

    localparam logic [31:0] BOOT_ADDR = 32'h0000_0000;
    localparam int          TIMEOUT   = 16;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in = 1'b0;
    logic        imem_rvalid_in = 1'b0;
    logic [31:0] imem_rdata_in = 32'h0;
    logic        redirect_in = 1'b0;
    logic [31:0] redirect_pc_in = 32'h0;
    logic        stall_in = 1'b0;
    logic        instr_valid_out;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        flush_out;
    logic        fetch_err_out;

    int checks = 0;
    int errors = 0;

    // Stimulus knobs and the memory's pending-response countdown
    int gnt_pct, stall_pct, redir_pct, lat_min, lat_max;
    int mem_wait;

    // Reference model: fetched-but-unconsumed words as a queue of {pc, instr}
    logic [63:0] m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_req_pc;
    bit          m_boot;
    bit          m_out;
    bit          m_discard;
    bit          m_err;
    bit          m_flush;
    int          m_waitc;

    always #5 clk = ~clk;

    msrv32_fetch_ctrl #(
        .BOOT_ADDR      (BOOT_ADDR),
        .TIMEOUT_CYCLES (TIMEOUT),
        .NOP_INSTR      (NOP)
    ) dut (
        .ms_riscv32_mp_clk_in (clk),
        .ms_riscv32_mp_rst_in (rst_n),
        .imem_req_out         (imem_req_out),
        .imem_addr_out        (imem_addr_out),
        .imem_gnt_in          (imem_gnt_in),
        .imem_rvalid_in       (imem_rvalid_in),
        .imem_rdata_in        (imem_rdata_in),
        .redirect_in          (redirect_in),
        .redirect_pc_in       (redirect_pc_in),
        .stall_in             (stall_in),
        .instr_valid_out      (instr_valid_out),
        .instr_out            (instr_out),
        .pc_out               (pc_out),
        .flush_out            (flush_out),
        .fetch_err_out        (fetch_err_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic bit modelReq();
        return !m_boot && !m_out && (m_q.size() < 2);
    endfunction

    task automatic modelReset();
        m_q.delete();
        m_pc      = BOOT_ADDR;
        m_req_pc  = BOOT_ADDR;
        m_boot    = 1'b1;
        m_out     = 1'b0;
        m_discard = 1'b0;
        m_err     = 1'b0;
        m_flush   = 1'b0;
        m_waitc   = 0;
        mem_wait  = 0;
    endtask

    // Drives one cycle of random inputs; the memory answers a grant after its chosen latency
    task automatic applyStimulus();
        redirect_in    = ($urandom_range(99) < redir_pct);
        redirect_pc_in = $urandom;
        stall_in       = ($urandom_range(99) < stall_pct);
        imem_gnt_in    = ($urandom_range(99) < gnt_pct);
        imem_rdata_in  = $urandom;
        if (mem_wait > 0) begin
            mem_wait--;
            imem_rvalid_in = (mem_wait == 0);
        end else begin
            imem_rvalid_in = 1'b0;
        end
    endtask

    task automatic compareOutputs();
        bit exp_req;
        exp_req = modelReq();
        checkOutput("imem_req", imem_req_out, exp_req);
        if (exp_req) checkOutput("imem_addr", imem_addr_out, m_pc);
        checkOutput("instr_valid", instr_valid_out, m_q.size() > 0);
        if (m_q.size() > 0) begin
            checkOutput("instr", instr_out, m_q[0][31:0]);
            checkOutput("pc", pc_out, m_q[0][63:32]);
        end else begin
            checkOutput("instr_nop", instr_out, NOP);
        end
        checkOutput("flush", flush_out, m_flush);
        checkOutput("fetch_err", fetch_err_out, m_err);
    endtask

    // Advances the model by one clock using the inputs presented this cycle
    task automatic modelStep();
        bit granted;
        bit popv;
        granted = modelReq() && imem_gnt_in;
        popv    = (m_q.size() > 0) && !stall_in;
        if (granted) mem_wait = $urandom_range(lat_max, lat_min);
        if (redirect_in) begin
            m_q.delete();
            m_pc    = redirect_pc_in & 32'hFFFF_FFFC;
            m_err   = 1'b0;
            m_waitc = 0;
            m_flush = 1'b1;
            m_boot  = 1'b0;
            if (m_out && imem_rvalid_in) begin
                m_out     = 1'b0;
                m_discard = 1'b0;
            end else if (m_out || granted) begin
                m_out     = 1'b1;
                m_discard = 1'b1;
            end
        end else begin
            m_flush = 1'b0;
            if (popv) void'(m_q.pop_front());
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (!m_out) begin
                if (granted) begin
                    m_out     = 1'b1;
                    m_discard = 1'b0;
                    m_req_pc  = m_pc;
                    m_pc      = m_pc + 32'd4;
                    m_waitc   = 0;
                end
            end else if (imem_rvalid_in) begin
                if (!m_discard) m_q.push_back({m_req_pc, imem_rdata_in});
                m_out     = 1'b0;
                m_discard = 1'b0;
            end else begin
                m_waitc++;
                if (m_waitc >= TIMEOUT) m_err = 1'b1;
            end
        end
    endtask

    task automatic runCycle();
        applyStimulus();
        @(negedge clk);
        compareOutputs();
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic runPhase(input int n, input int g, input int s, input int r, input int lmin, input int lmax);
        gnt_pct   = g;
        stall_pct = s;
        redir_pct = r;
        lat_min   = lmin;
        lat_max   = lmax;
        for (int i = 0; i < n; i++) runCycle();
    endtask

    // Asserts reset between edges, checks outputs before any clock edge, then releases
    task automatic doReset();
        #3;
        rst_n          = 1'b0;
        redirect_in    = 1'b0;
        stall_in       = 1'b0;
        imem_gnt_in    = 1'b0;
        imem_rvalid_in = 1'b0;
        #1;
        checkOutput("rst_req", imem_req_out, 1'b0);
        checkOutput("rst_addr", imem_addr_out, BOOT_ADDR);
        checkOutput("rst_valid", instr_valid_out, 1'b0);
        checkOutput("rst_instr", instr_out, NOP);
        checkOutput("rst_pc", pc_out, BOOT_ADDR);
        checkOutput("rst_flush", flush_out, 1'b0);
        checkOutput("rst_err", fetch_err_out, 1'b0);
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        doReset();
        // Zero-wait memory, then a long stall filling both buffer slots, then drain
        runPhase(20, 100, 0, 0, 1, 1);
        runPhase(12, 100, 100, 0, 1, 1);
        runPhase(10, 100, 0, 0, 1, 1);
        runPhase(400, 80, 25, 5, 1, 4);
        runPhase(300, 70, 30, 30, 1, 3);
        // Slow memory long enough to trip the timeout, with occasional redirects to clear it
        runPhase(300, 100, 20, 3, 18, 22);
        runPhase(100, 90, 20, 10, 1, 3);
        // Reset while a live fetch is outstanding
        gnt_pct = 100; stall_pct = 0; redir_pct = 0; lat_min = 6; lat_max = 8;
        guard = 0;
        while (!(m_out && !m_discard) && guard < 100) begin
            runCycle();
            guard++;
        end
        checkOutput("reset_setup_outstanding", m_out, 1'b1);
        doReset();
        runPhase(200, 80, 25, 5, 1, 4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
